// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter for the Tomasulo core.
// Two one-entry holding buffers (adder, multiplier) feed a single registered
// CDB broadcast. The grant goes round-robin between the buffers.
// Handshake: a result moves into a holding buffer on any rising clock edge
// where valid and ready are both high. The source must keep tag and data
// stable while valid=1 and ready=0.
// Optional feature macro: CDB_STATS_EN builds the broadcast and conflict
// counters. When the macro is undefined, both counter ports read 0.
module cdb_arbiter #(
  parameter int DATA_W = 9,
  parameter int TAG_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              add_valid,
  input  logic [TAG_W-1:0]  add_tag,
  input  logic [DATA_W-1:0] add_data,
  output logic              add_ready,
  input  logic              mul_valid,
  input  logic [TAG_W-1:0]  mul_tag,
  input  logic [DATA_W-1:0] mul_data,
  output logic              mul_ready,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_src,
  output logic              cdb_err,
  output logic [CNT_W-1:0]  cnt_bcast,
  output logic [CNT_W-1:0]  cnt_conflict
);

  logic              hold_add_v_q, hold_add_v_d;
  logic [TAG_W-1:0]  hold_add_tag_q, hold_add_tag_d;
  logic [DATA_W-1:0] hold_add_data_q, hold_add_data_d;
  logic              hold_mul_v_q, hold_mul_v_d;
  logic [TAG_W-1:0]  hold_mul_tag_q, hold_mul_tag_d;
  logic [DATA_W-1:0] hold_mul_data_q, hold_mul_data_d;
  logic              prio_q, prio_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              cdb_src_q, cdb_src_d;
  logic              cdb_err_q, cdb_err_d;

  logic grant_add, grant_mul;
  logic add_xfer, mul_xfer;

  // Grant selection: a single pending buffer wins, and prio breaks a tie. Flush blocks every grant.
  always_comb begin
    grant_add = 1'b0;
    grant_mul = 1'b0;
    if (!flush) begin
      if (hold_add_v_q && hold_mul_v_q) begin
        grant_add = !prio_q;
        grant_mul = prio_q;
      end else begin
        grant_add = hold_add_v_q;
        grant_mul = hold_mul_v_q;
      end
    end
  end

  // A buffer accepts a new result when it is empty or when it drains on this edge.
  assign add_ready = !flush && (!hold_add_v_q || grant_add);
  assign mul_ready = !flush && (!hold_mul_v_q || grant_mul);
  assign add_xfer  = add_valid && add_ready;
  assign mul_xfer  = mul_valid && mul_ready;

  // Next-state logic for the buffers, the round-robin pointer, the CDB registers and the error flag.
  always_comb begin
    hold_add_v_d    = hold_add_v_q;
    hold_add_tag_d  = hold_add_tag_q;
    hold_add_data_d = hold_add_data_q;
    hold_mul_v_d    = hold_mul_v_q;
    hold_mul_tag_d  = hold_mul_tag_q;
    hold_mul_data_d = hold_mul_data_q;
    prio_d          = prio_q;
    cdb_valid_d     = grant_add || grant_mul;
    cdb_tag_d       = cdb_tag_q;
    cdb_data_d      = cdb_data_q;
    cdb_src_d       = cdb_src_q;
    cdb_err_d       = cdb_err_q
                      || (add_xfer && (add_tag == '0))
                      || (mul_xfer && (mul_tag == '0));

    if (flush) begin
      hold_add_v_d = 1'b0;
      hold_mul_v_d = 1'b0;
    end else begin
      if (grant_add) hold_add_v_d = 1'b0;
      if (grant_mul) hold_mul_v_d = 1'b0;
      // A tag-0 result is accepted but dropped, so the buffer stays empty.
      if (add_xfer) begin
        hold_add_v_d    = (add_tag != '0);
        hold_add_tag_d  = add_tag;
        hold_add_data_d = add_data;
      end
      if (mul_xfer) begin
        hold_mul_v_d    = (mul_tag != '0);
        hold_mul_tag_d  = mul_tag;
        hold_mul_data_d = mul_data;
      end
    end

    if (grant_add) begin
      prio_d     = 1'b1;
      cdb_tag_d  = hold_add_tag_q;
      cdb_data_d = hold_add_data_q;
      cdb_src_d  = 1'b0;
    end else if (grant_mul) begin
      prio_d     = 1'b0;
      cdb_tag_d  = hold_mul_tag_q;
      cdb_data_d = hold_mul_data_q;
      cdb_src_d  = 1'b1;
    end
  end

  // State registers with a synchronous reset. Reset overrides flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_add_v_q    <= 1'b0;
      hold_add_tag_q  <= '0;
      hold_add_data_q <= '0;
      hold_mul_v_q    <= 1'b0;
      hold_mul_tag_q  <= '0;
      hold_mul_data_q <= '0;
      prio_q          <= 1'b0;
      cdb_valid_q     <= 1'b0;
      cdb_tag_q       <= '0;
      cdb_data_q      <= '0;
      cdb_src_q       <= 1'b0;
      cdb_err_q       <= 1'b0;
    end else begin
      hold_add_v_q    <= hold_add_v_d;
      hold_add_tag_q  <= hold_add_tag_d;
      hold_add_data_q <= hold_add_data_d;
      hold_mul_v_q    <= hold_mul_v_d;
      hold_mul_tag_q  <= hold_mul_tag_d;
      hold_mul_data_q <= hold_mul_data_d;
      prio_q          <= prio_d;
      cdb_valid_q     <= cdb_valid_d;
      cdb_tag_q       <= cdb_tag_d;
      cdb_data_q      <= cdb_data_d;
      cdb_src_q       <= cdb_src_d;
      cdb_err_q       <= cdb_err_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
  assign cdb_err   = cdb_err_q;

`ifdef CDB_STATS_EN
  logic [CNT_W-1:0] cnt_bcast_q, cnt_bcast_d;
  logic [CNT_W-1:0] cnt_conflict_q, cnt_conflict_d;
  logic             conflict;

  assign conflict = hold_add_v_q && hold_mul_v_q && !flush;

  // Saturating counters: one counts broadcasts, the other counts cycles where both buffers are pending.
  always_comb begin
    cnt_bcast_d    = cnt_bcast_q;
    cnt_conflict_d = cnt_conflict_q;
    if (cdb_valid_d && (cnt_bcast_q != {CNT_W{1'b1}}))
      cnt_bcast_d = cnt_bcast_q + 1'b1;
    if (conflict && (cnt_conflict_q != {CNT_W{1'b1}}))
      cnt_conflict_d = cnt_conflict_q + 1'b1;
  end

  // Counter registers. Flush does not change them.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_bcast_q    <= '0;
      cnt_conflict_q <= '0;
    end else begin
      cnt_bcast_q    <= cnt_bcast_d;
      cnt_conflict_q <= cnt_conflict_d;
    end
  end

  assign cnt_bcast    = cnt_bcast_q;
  assign cnt_conflict = cnt_conflict_q;
`else
  assign cnt_bcast    = '0;
  assign cnt_conflict = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter.
// A reference model holds each unit's pending result as a queue of depth at most 1.
// The stimulus task predicts the ready outputs, the error flag and the counters,
// and pushes every expected broadcast into exp_q. A separate monitor pops
// exp_q one edge later and compares it with the CDB outputs.
module tb_cdb_arbiter;
  localparam int DW   = 9;
  localparam int TW   = 3;
  localparam int CW   = 8;
  localparam int EW   = 1 + TW + DW;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          add_valid = 1'b0;
  logic [TW-1:0] add_tag = '0;
  logic [DW-1:0] add_data = '0;
  logic          add_ready;
  logic          mul_valid = 1'b0;
  logic [TW-1:0] mul_tag = '0;
  logic [DW-1:0] mul_data = '0;
  logic          mul_ready;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic          cdb_src;
  logic          cdb_err;
  logic [CW-1:0] cnt_bcast;
  logic [CW-1:0] cnt_conflict;

  // Clock generation.
  always #5 clock = ~clock;

  cdb_arbiter #(.DATA_W(DW), .TAG_W(TW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .add_valid(add_valid), .add_tag(add_tag), .add_data(add_data), .add_ready(add_ready),
    .mul_valid(mul_valid), .mul_tag(mul_tag), .mul_data(mul_data), .mul_ready(mul_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src),
    .cdb_err(cdb_err), .cnt_bcast(cnt_bcast), .cnt_conflict(cnt_conflict)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Scoreboard and reference model state.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] slot_a[$];
  logic [EW-1:0] slot_m[$];
  logic          prio_m = 1'b0;
  logic          err_m = 1'b0;
  int            cb_m = 0;
  int            cc_m = 0;
  logic          pulse_pend = 1'b0;
  bit            mon_en = 1'b0;

  // Source state: the payload each unit presents, and whether it transferred on the last edge.
  logic          a_v = 1'b0, m_v = 1'b0;
  logic [TW-1:0] a_t = '0, m_t = '0;
  logic [DW-1:0] a_d = '0, m_d = '0;
  logic          xa = 1'b0, xm = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_counters();
`ifdef CDB_STATS_EN
    chk("cnt_bcast", 32'(cnt_bcast), 32'(cb_m));
    chk("cnt_conflict", 32'(cnt_conflict), 32'(cc_m));
`else
    chk("cnt_bcast_off", 32'(cnt_bcast), 32'd0);
    chk("cnt_conflict_off", 32'(cnt_conflict), 32'd0);
`endif
  endtask

  // Drive one cycle of stimulus and advance the reference model across the next rising edge.
  task automatic step(input logic fl, input logic rst);
    logic win_a, win_m, ra, rm, pa, pm;
    @(negedge clock);
    if (mon_en) begin
      chk("cdb_err", 32'(cdb_err), 32'(err_m));
      chk_counters();
    end
    reset = rst; flush = fl;
    add_valid = a_v; add_tag = a_t; add_data = a_d;
    mul_valid = m_v; mul_tag = m_t; mul_data = m_d;
    #1;
    if (rst) begin
      slot_a.delete(); slot_m.delete(); exp_q.delete();
      prio_m = 1'b0; err_m = 1'b0; cb_m = 0; cc_m = 0;
      pulse_pend = 1'b0; xa = 1'b0; xm = 1'b0;
    end else begin
      pa = (slot_a.size() != 0);
      pm = (slot_m.size() != 0);
      win_a = 1'b0; win_m = 1'b0;
      if (!fl) begin
        if (pa && pm) begin
          win_a = (prio_m == 1'b0);
          win_m = (prio_m == 1'b1);
        end else begin
          win_a = pa;
          win_m = pm;
        end
      end
      ra = !fl && (!pa || win_a);
      rm = !fl && (!pm || win_m);
      chk("add_ready", 32'(add_ready), 32'(ra));
      chk("mul_ready", 32'(mul_ready), 32'(rm));
      if (!fl && pa && pm && cc_m < CMAX) cc_m++;
      pulse_pend = win_a || win_m;
      if (pulse_pend && cb_m < CMAX) cb_m++;
      if (win_a) begin
        exp_q.push_back(slot_a.pop_front());
        prio_m = 1'b1;
      end else if (win_m) begin
        exp_q.push_back(slot_m.pop_front());
        prio_m = 1'b0;
      end
      if (fl) begin
        slot_a.delete();
        slot_m.delete();
      end
      xa = a_v && ra;
      xm = m_v && rm;
      if (xa) begin
        if (a_t == '0) err_m = 1'b1;
        else slot_a.push_back({1'b0, a_t, a_d});
      end
      if (xm) begin
        if (m_t == '0) err_m = 1'b1;
        else slot_m.push_back({1'b1, m_t, m_d});
      end
    end
  endtask

  // Monitor: compares each CDB pulse with the next expected entry, 1 time unit after the edge.
  always @(posedge clock) begin
    logic [EW-1:0] e;
    #1;
    if (mon_en) begin
      chk("cdb_valid", 32'(cdb_valid), 32'(pulse_pend));
      if (pulse_pend) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL exp_q_underflow: got pulse expected queued entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("cdb_src", 32'(cdb_src), 32'(e[EW-1]));
          chk("cdb_tag", 32'(cdb_tag), 32'(e[DW +: TW]));
          chk("cdb_data", 32'(cdb_data), 32'(e[DW-1:0]));
        end
      end
    end
  end

  initial begin
    mon_en = 1'b1;
    // Hold reset for 2 cycles with both sources idle.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(posedge clock); #2;
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    chk("rst_cdb_data", 32'(cdb_data), 32'd0);
    chk("rst_cdb_src", 32'(cdb_src), 32'd0);
    chk("rst_cdb_err", 32'(cdb_err), 32'd0);
    chk("rst_cnt_bcast", 32'(cnt_bcast), 32'd0);
    chk("rst_cnt_conflict", 32'(cnt_conflict), 32'd0);
    reset = 1'b0; #1;
    chk("rst_add_ready", 32'(add_ready), 32'd1);
    chk("rst_mul_ready", 32'(mul_ready), 32'd1);
    repeat (2) step(1'b0, 1'b0);

    // The adder sends two results back to back.
    a_v = 1'b1; a_t = 3'd1; a_d = 9'd5; step(1'b0, 1'b0);
    a_t = 3'd2; a_d = 9'd7; step(1'b0, 1'b0);
    a_v = 1'b0; repeat (3) step(1'b0, 1'b0);

    // Both sources stay valid every cycle, so the grant alternates.
    a_v = 1'b1; a_t = 3'd1; a_d = 9'd10;
    m_v = 1'b1; m_t = 3'd4; m_d = 9'd20;
    repeat (8) step(1'b0, 1'b0);
    a_v = 1'b0; m_v = 1'b0; repeat (3) step(1'b0, 1'b0);

    // The multiplier sends tag 0, then valid traffic follows.
    m_v = 1'b1; m_t = 3'd0; m_d = 9'd3; step(1'b0, 1'b0);
    m_v = 1'b0; repeat (2) step(1'b0, 1'b0);
    m_v = 1'b1; m_t = 3'd5; m_d = 9'd33; step(1'b0, 1'b0);
    m_v = 1'b0; repeat (3) step(1'b0, 1'b0);

    // Load both buffers, then flush for one cycle, then send a normal adder result.
    a_v = 1'b1; a_t = 3'd5; a_d = 9'd100;
    m_v = 1'b1; m_t = 3'd6; m_d = 9'd200;
    step(1'b0, 1'b0);
    a_v = 1'b0; m_v = 1'b0; step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    a_v = 1'b1; a_t = 3'd3; a_d = 9'd42; step(1'b0, 1'b0);
    a_v = 1'b0; repeat (3) step(1'b0, 1'b0);

    // Random traffic with occasional flushes and tag-0 results.
    for (int i = 0; i < 400; i++) begin
      if (!a_v || xa) begin
        a_v = ($urandom_range(0, 3) != 0);
        a_t = ($urandom_range(0, 15) == 0) ? 3'd0 : TW'($urandom_range(1, 7));
        a_d = DW'($urandom_range(0, 511));
      end
      if (!m_v || xm) begin
        m_v = ($urandom_range(0, 3) != 0);
        m_t = ($urandom_range(0, 15) == 0) ? 3'd0 : TW'($urandom_range(1, 7));
        m_d = DW'($urandom_range(0, 511));
      end
      step(($urandom_range(0, 19) == 0), 1'b0);
    end
    a_v = 1'b0; m_v = 1'b0; repeat (3) step(1'b0, 1'b0);

    // Reset in the middle of traffic, then 300 single-source broadcasts to saturate the counters.
    a_v = 1'b1; m_v = 1'b1; a_t = 3'd2; m_t = 3'd3; step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    a_v = 1'b0; m_v = 1'b0; step(1'b0, 1'b1);
    a_v = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a_t = TW'($urandom_range(1, 7));
      a_d = DW'($urandom_range(0, 511));
      step(1'b0, 1'b0);
    end
    a_v = 1'b0; repeat (3) step(1'b0, 1'b0);
    #2;
`ifdef CDB_STATS_EN
    chk("cnt_bcast_sat", 32'(cnt_bcast), 32'd255);
`else
    chk("cnt_bcast_off_end", 32'(cnt_bcast), 32'd0);
    chk("cnt_conflict_off_end", 32'(cnt_conflict), 32'd0);
`endif
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
